// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the raw keyboard clock/data pins,
// deframes device-to-host bytes and turns scan-code sequences into the
// 11-bit key-event word {toggle, pressed, ext, code} used by the core.

module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic raw_in,
    output logic filt_out
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchronizer for the asynchronous pin; idles high like the bus.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has held for FILT_LEN consecutive cycles.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            filt_out   <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_2 == filt_out) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(FILT_LEN - 1)) begin
            filt_out   <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

endmodule

module ps2_key_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 28000,
    parameter int TO_W        = 15
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [10:0] KEY,
    output logic        KEY_STB,
    output logic        ERR,
    output logic        RX_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    logic            clk_filt;
    logic            dat_filt;
    logic            clk_filt_d;
    logic            fall_stb;

    rx_state_t       state;
    rx_state_t       state_n;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_n;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_n;
    logic            par_bit;
    logic            par_n;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_n;
    logic            err_set;
    logic            byte_ok;

    logic            err_q;
    logic            byte_vld;
    logic [7:0]      byte_q;

    logic [2:0]      skip_cnt;
    logic            ext_flag;
    logic            brk_flag;
    logic [10:0]     key_q;
    logic            key_stb_q;
    logic            is_filler;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_sys  (MCLK),
        .rst_n    (RST_N),
        .raw_in   (PS2_CLK),
        .filt_out (clk_filt)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk_sys  (MCLK),
        .rst_n    (RST_N),
        .raw_in   (PS2_DAT),
        .filt_out (dat_filt)
    );

    // Delayed copy of the filtered clock so a 1->0 transition becomes a one-cycle strobe.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign fall_stb = clk_filt_d & ~clk_filt;

    // Frame state register together with the bit, shift, parity and timeout state.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            par_bit   <= par_n;
            to_cnt    <= to_n;
        end
    end

    // Frame deframing: every move happens on a falling-edge strobe, except the timeout abort.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        par_n     = par_bit;
        to_n      = to_cnt;
        err_set   = 1'b0;
        byte_ok   = 1'b0;

        if (state == ST_IDLE || fall_stb) begin
            to_n = '0;
        end else begin
            to_n = to_cnt + TO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (fall_stb) begin
                    if (!dat_filt) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall_stb) begin
                    shift_n   = {dat_filt, shift_reg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_stb) begin
                    par_n   = dat_filt;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_stb) begin
                    state_n = ST_IDLE;
                    if (dat_filt && (^{shift_reg, par_bit})) begin
                        byte_ok = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state != ST_IDLE && !fall_stb && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err_set = 1'b1;
            state_n = ST_IDLE;
            to_n    = '0;
        end
    end

    // Register the frame verdict so byte processing runs one cycle after the stop bit.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q    <= 1'b0;
            byte_vld <= 1'b0;
            byte_q   <= '0;
        end else begin
            err_q    <= err_set;
            byte_vld <= byte_ok;
            if (byte_ok) begin
                byte_q <= shift_reg;
            end
        end
    end

    // Keyboard self-test/ack/overrun bytes that carry no key information on their own.
    always_comb begin
        is_filler = 1'b0;
        case (byte_q)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_filler = 1'b1;
            default:                                  is_filler = 1'b0;
        endcase
    end

    // Scan-code interpretation: Pause skipping, E0/F0 prefixes, fillers, then key events.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            skip_cnt  <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_q     <= '0;
            key_stb_q <= 1'b0;
        end else begin
            key_stb_q <= 1'b0;
            if (err_q) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_vld) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (byte_q == 8'hE1) begin
                    skip_cnt <= 3'd7;
                end else if (byte_q == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (is_filler && !ext_flag && !brk_flag) begin
                    key_stb_q <= 1'b0;
                end else begin
                    key_q     <= {~key_q[10], ~brk_flag, ext_flag, byte_q};
                    key_stb_q <= 1'b1;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

    assign KEY     = key_q;
    assign KEY_STB = key_stb_q;
    assign ERR     = err_q;
    assign RX_BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Testbench for ps2_key_rx: drives PS/2 frames on the pins and compares the
// key-event outputs against a scan-code level model of the keyboard protocol.

module tb_ps2_key_rx;

    localparam int FILT = 8;
    localparam int TOUT = 1000;

    logic        MCLK = 1'b0;
    logic        RST_N;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic [10:0] KEY;
    logic        KEY_STB;
    logic        ERR;
    logic        RX_BUSY;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int silent_key_cnt = 0;
    logic [10:0] prev_key = '0;

    logic [10:0] m_key;
    bit          m_ext;
    bit          m_brk;
    int          m_skip;
    int          m_stb_total;

    ps2_key_rx #(
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TOUT),
        .TO_W        (10)
    ) dut (
        .MCLK    (MCLK),
        .RST_N   (RST_N),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .KEY     (KEY),
        .KEY_STB (KEY_STB),
        .ERR     (ERR),
        .RX_BUSY (RX_BUSY)
    );

    // Free-running system clock.
    always #5 MCLK = ~MCLK;

    // Pulse counters and invariant watchers, sampled away from the active edge.
    always @(negedge MCLK) begin
        if (RST_N) begin
            if (KEY_STB) stb_cnt++;
            if (ERR) err_cnt++;
            if (KEY_STB && ERR) overlap_cnt++;
            if (KEY !== prev_key && !KEY_STB) silent_key_cnt++;
        end
        prev_key = KEY;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic clockBit(input logic d);
        int half;
        half = $urandom_range(16, 26);
        PS2_DAT = d;
        waitCycles(half / 2);
        PS2_CLK = 1'b0;
        waitCycles(half);
        PS2_CLK = 1'b1;
        waitCycles(half / 2);
    endtask

    task automatic modelReset();
        m_key  = '0;
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
    endtask

    task automatic modelError();
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic modelByte(input logic [7:0] b);
        bit filler;
        filler = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
                 (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (filler && !m_ext && !m_brk) begin
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_stb_total++;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        int   s0;
        int   e0;
        int   t0;
        int   exp_err;
        logic par;
        s0 = stb_cnt;
        e0 = err_cnt;
        t0 = m_stb_total;
        par = (~^b) ^ bad_par;
        clockBit(1'b0);
        for (int i = 0; i < 8; i++) clockBit(b[i]);
        clockBit(par);
        clockBit(~bad_stop);
        PS2_DAT = 1'b1;
        waitCycles(12);
        if (bad_par || bad_stop) begin
            exp_err = 1;
            modelError();
        end else begin
            exp_err = 0;
            modelByte(b);
        end
        checkOutput($sformatf("%s_stb", tag), stb_cnt - s0, m_stb_total - t0);
        checkOutput($sformatf("%s_err", tag), err_cnt - e0, exp_err);
        checkOutput($sformatf("%s_key", tag), KEY, m_key);
        checkOutput($sformatf("%s_busy", tag), RX_BUSY, 0);
    endtask

    initial begin
        int s0;
        int e0;
        logic [7:0] pause_seq [8];
        logic [7:0] filler_set [6];
        pause_seq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        filler_set = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        m_stb_total = 0;
        modelReset();

        RST_N   = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        waitCycles(3);
        checkOutput("rst_key", KEY, 0);
        checkOutput("rst_stb", KEY_STB, 0);
        checkOutput("rst_err", ERR, 0);
        checkOutput("rst_busy", RX_BUSY, 0);
        RST_N = 1'b1;
        waitCycles(30);

        $display("[TB] directed key sequences");
        applyStimulus(8'h1C, 0, 0, "make_1c");
        checkOutput("make_1c_abs", KEY, 11'h61C);
        applyStimulus(8'hF0, 0, 0, "brk_f0");
        applyStimulus(8'h1C, 0, 0, "brk_1c");
        checkOutput("brk_1c_abs", KEY, 11'h01C);
        applyStimulus(8'hE0, 0, 0, "ext_e0");
        applyStimulus(8'h75, 0, 0, "ext_75");
        checkOutput("ext_75_abs", KEY, 11'h775);
        applyStimulus(8'hE0, 0, 0, "extbrk_e0");
        applyStimulus(8'hF0, 0, 0, "extbrk_f0");
        applyStimulus(8'h75, 0, 0, "extbrk_75");
        checkOutput("extbrk_75_abs", KEY, 11'h175);
        applyStimulus(8'h29, 1, 0, "badpar_29");
        applyStimulus(8'h29, 0, 0, "good_29");
        checkOutput("good_29_abs", KEY, 11'h629);
        applyStimulus(8'h33, 0, 1, "badstop_33");

        $display("[TB] timeout and start-bit error");
        s0 = stb_cnt;
        e0 = err_cnt;
        clockBit(1'b0);
        clockBit(1'b1);
        clockBit(1'b0);
        clockBit(1'b1);
        clockBit(1'b0);
        checkOutput("to_busy_mid", RX_BUSY, 1);
        PS2_DAT = 1'b1;
        waitCycles(2 * TOUT);
        modelError();
        checkOutput("to_err", err_cnt - e0, 1);
        checkOutput("to_stb", stb_cnt - s0, 0);
        checkOutput("to_busy_after", RX_BUSY, 0);
        applyStimulus(8'h16, 0, 0, "after_to_16");

        s0 = stb_cnt;
        e0 = err_cnt;
        clockBit(1'b1);
        waitCycles(12);
        modelError();
        checkOutput("start1_err", err_cnt - e0, 1);
        checkOutput("start1_stb", stb_cnt - s0, 0);
        checkOutput("start1_busy", RX_BUSY, 0);

        $display("[TB] pause sequence");
        for (int i = 0; i < 8; i++) applyStimulus(pause_seq[i], 0, 0, $sformatf("pause%0d", i));
        applyStimulus(8'h16, 0, 0, "after_pause_16");

        $display("[TB] reset mid-frame");
        clockBit(1'b0);
        clockBit(1'b1);
        clockBit(1'b1);
        clockBit(1'b0);
        checkOutput("mid_busy", RX_BUSY, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("mid_rst_key", KEY, 0);
        checkOutput("mid_rst_stb", KEY_STB, 0);
        checkOutput("mid_rst_err", ERR, 0);
        checkOutput("mid_rst_busy", RX_BUSY, 0);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        waitCycles(5);
        RST_N = 1'b1;
        modelReset();
        waitCycles(30);
        applyStimulus(8'h16, 0, 0, "post_rst_16");
        checkOutput("post_rst_16_abs", KEY, 11'h616);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            int          sel;
            logic [7:0]  b;
            bit          bp;
            bit          bs;
            sel = $urandom_range(0, 11);
            case (sel)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'hE1;
                3:       b = filler_set[$urandom_range(0, 5)];
                4:       b = 8'hE0;
                5:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 11) == 0);
            applyStimulus(b, bp, bs, $sformatf("rnd%0d", i));
        end

        checkOutput("stb_err_overlap", overlap_cnt, 0);
        checkOutput("key_change_without_stb", silent_key_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Receives raw PS/2 keyboard serial traffic (device-to-host frames) and produces the 11-bit key-event word used by the core keyboard handlers: bit10 toggle, bit9 pressed, bit8 extended, bits7:0 scan code.
- Sits between the keyboard pins and any consumer that watches the toggle bit, e.g. the top-level button-latch logic.
- Receive-only; never drives the PS/2 lines.

Parameters:
- FILT_LEN, 8, number of consecutive MCLK cycles a synchronized PS/2 line must hold a new level before the filtered level changes.
- TIMEOUT_CYC, 28000, MCLK cycles with no filtered clock falling edge before an in-progress frame is aborted (about 2 ms at 14.3 MHz).
- TO_W, 15, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- MCLK in 1: system clock.
- RST_N in 1: reset, asynchronous, active-low.
- PS2_CLK in 1: raw keyboard clock, asynchronous to MCLK.
- PS2_DAT in 1: raw keyboard data, asynchronous to MCLK.
- KEY out 11: key-event word {toggle, pressed, ext, code[7:0]}.
- KEY_STB out 1: one-cycle pulse, high in the same cycle KEY changes.
- ERR out 1: one-cycle pulse on a parity, framing or timeout error.
- RX_BUSY out 1: high while a frame is in progress (from start bit to stop bit).

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect at any time including mid-frame):
  - KEY=0, KEY_STB=0, ERR=0, RX_BUSY=0.
  - FSM goes to IDLE; bit counter, timeout counter, E0/F0 flags and pause-skip count all cleared.
  - Filtered clock and filtered data are set to 1.
- Input conditioning:
  - Each input passes through a 2-FF synchronizer, then the FILT_LEN stability filter.
  - A falling edge is a filtered-clock 1->0 transition, detected as a one-cycle internal strobe.
  - Data is sampled as the filtered data value in the same cycle as that strobe.
  - Latency from a raw pin edge to the internal strobe is at most FILT_LEN+4 cycles.
- Frame FSM (all transitions happen on a falling-edge strobe):
  - IDLE: data=0 -> DATA with bit count 0, RX_BUSY=1. Data=1 -> ERR pulse, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 and odd parity over the 8 data bits plus the parity bit -> byte valid. Otherwise -> ERR pulse. Either way go to IDLE with RX_BUSY=0.
- Timeout:
  - The timeout counter runs only while RX_BUSY=1 and clears on every falling-edge strobe.
  - When it reaches TIMEOUT_CYC: ERR pulse, go to IDLE, clear the E0/F0 flags.
- Any ERR also clears the E0/F0 flags. The pause-skip count is unaffected by errors.
- Byte processing happens in the cycle after the valid-byte decision, in this priority order:
  - Pause-skip count nonzero: decrement it and discard the byte.
  - 0xE1: load pause-skip count = 7, discard the byte.
  - 0xE0: set the ext flag.
  - 0xF0: set the brk flag.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00 or 0xFF with both flags clear: discard.
  - Any other byte: KEY <= {~KEY[10], ~brk, ext, byte}, KEY_STB=1 for exactly one cycle, then clear both flags.
- Prefix bytes (0xE0, 0xF0) never produce KEY_STB.
- KEY holds its value between events.
- KEY_STB and ERR are never high in the same cycle.
- Total latency from the stop-bit strobe to KEY_STB is 2 MCLK cycles.

Test Plan:
- After reset, frame 0x1C with parity bit 0 and stop bit 1 -> one KEY_STB; KEY=0x61C; ERR never asserted.
- Next, frames F0 then 1C -> exactly one KEY_STB, after the 1C frame; KEY=0x01C (toggle back to 0, pressed=0).
- Next, frames E0 then 75 -> one KEY_STB; KEY=0x775. Then E0 F0 75 -> KEY=0x175.
- Frame 0x29 with parity bit 1 (bad parity) -> ERR pulse, no KEY_STB, KEY unchanged. Next a good 0x29 frame -> KEY_STB with KEY[7:0]=0x29 and the toggle inverted.
- Five clock edges, then the clock held high for 2×TIMEOUT_CYC -> ERR pulse once, RX_BUSY=0. Following frame 0x16 decodes correctly. Also: a start bit with data=1 -> ERR pulse only.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> no KEY_STB; a following 0x16 -> KEY_STB. RST_N pulsed low mid-frame -> all outputs 0 immediately; the next full frame decodes normally.
